// File: rtl/ps2_host_tx_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx_ctrl
// Brief    : PS/2 host-to-device command sender (inhibit, RTS, shift, ACK)
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx_ctrl #(
    parameter int INHIBIT_CYC = 5000,
    parameter int TIMEOUT_CYC = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    input  logic       KCLK,
    input  logic       KDAT,
    output logic       kclk_oe,
    output logic       kdat_oe,
    output logic       rx_enable,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int c_MAX_CYC = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_INH_DAT  = c_CNT_W'(INHIBIT_CYC - 2);
    localparam logic [c_CNT_W-1:0] c_INH_LAST = c_CNT_W'(INHIBIT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_INHIBIT   = 3'd1;
    localparam logic [2:0] c_ST_RTS       = 3'd2;
    localparam logic [2:0] c_ST_SHIFT     = 3'd3;
    localparam logic [2:0] c_ST_ACK       = 3'd4;
    localparam logic [2:0] c_ST_WAIT_IDLE = 3'd5;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_bit;
    logic [7:0]         r_data;
    logic               r_parity;
    logic               r_ack;
    logic               r_kclk_s1;
    logic               r_kclk_s2;
    logic               r_kclk_prev;
    logic               r_kdat_s1;
    logic               r_kdat_s2;
    logic               r_kclk_oe;
    logic               r_kdat_oe;
    logic               r_cmd_ready;
    logic               r_rx_enable;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic               w_fall;
    logic               w_timeout;

    assign w_fall    = r_kclk_prev & ~r_kclk_s2;
    assign w_timeout = (r_cnt == c_TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_bit       <= 4'd0;
            r_data      <= 8'd0;
            r_parity    <= 1'b0;
            r_ack       <= 1'b0;
            r_kclk_s1   <= 1'b1;
            r_kclk_s2   <= 1'b1;
            r_kclk_prev <= 1'b1;
            r_kdat_s1   <= 1'b1;
            r_kdat_s2   <= 1'b1;
            r_kclk_oe   <= 1'b0;
            r_kdat_oe   <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_rx_enable <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_kclk_s1   <= KCLK;
            r_kclk_s2   <= r_kclk_s1;
            r_kclk_prev <= r_kclk_s2;
            r_kdat_s1   <= KDAT;
            r_kdat_s2   <= r_kdat_s1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    r_rx_enable <= 1'b1;
                    r_busy      <= 1'b0;
                    r_kclk_oe   <= 1'b0;
                    r_kdat_oe   <= 1'b0;
                    if (cmd_valid && r_cmd_ready) begin
                        r_data      <= cmd_data;
                        r_parity    <= ~^cmd_data;
                        r_cnt       <= '0;
                        r_cmd_ready <= 1'b0;
                        r_rx_enable <= 1'b0;
                        r_busy      <= 1'b1;
                        r_kclk_oe   <= 1'b1;
                        r_state     <= c_ST_INHIBIT;
                    end
                end

                // Start bit goes low one cycle before KCLK is released.
                c_ST_INHIBIT: begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_INH_DAT) begin
                        r_kdat_oe <= 1'b1;
                    end
                    if (r_cnt == c_INH_LAST) begin
                        r_kclk_oe <= 1'b0;
                        r_state   <= c_ST_RTS;
                    end
                end

                // The RTS cycle is itself the first cycle after KCLK release.
                c_ST_RTS: begin
                    r_cnt   <= c_CNT_ONE;
                    r_bit   <= 4'd0;
                    r_state <= c_ST_SHIFT;
                end

                c_ST_SHIFT, c_ST_ACK: begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (w_timeout) begin
                        r_kdat_oe <= 1'b0;
                        r_kclk_oe <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= c_ST_IDLE;
                    end else if (w_fall) begin
                        if (r_state == c_ST_ACK) begin
                            r_ack   <= ~r_kdat_s2;
                            r_state <= c_ST_WAIT_IDLE;
                        end else begin
                            r_bit <= r_bit + 4'd1;
                            if (r_bit < 4'd8) begin
                                r_kdat_oe <= ~r_data[r_bit[2:0]];
                            end else if (r_bit == 4'd8) begin
                                r_kdat_oe <= ~r_parity;
                            end else begin
                                r_kdat_oe <= 1'b0;
                                r_state   <= c_ST_ACK;
                            end
                        end
                    end
                end

                c_ST_WAIT_IDLE: begin
                    if (r_kclk_s2 && r_kdat_s2) begin
                        r_done  <= r_ack;
                        r_err   <= ~r_ack;
                        r_state <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_kclk_oe <= 1'b0;
                    r_kdat_oe <= 1'b0;
                    r_state   <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign kclk_oe   = r_kclk_oe;
    assign kdat_oe   = r_kdat_oe;
    assign rx_enable = r_rx_enable;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: doc/ps2_host_tx_ctrl.md
# ps2_host_tx_ctrl

Host-to-device controller for the PS/2 keyboard port. It accepts a command byte, such as 0xED (set LEDs) or 0xF4 (enable), from the system side. It then runs the PS/2 host-request sequence on the shared KCLK/KDAT lines: inhibit, request-to-send, bit shifting and ACK check. It owns the open-collector drive enables and gates the existing scan-code receiver through `rx_enable`, so only one side uses the bus at a time.

## Interface
- `INHIBIT_CYC`, 5000: clk cycles KCLK is held low before request-to-send (100 µs at 50 MHz).
- `TIMEOUT_CYC`, 750000: maximum clk cycles from KCLK release to ACK sampled (15 ms at 50 MHz).
- `clk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command byte offered.
- `cmd_data` in 8: command byte, LSB sent first.
- `cmd_ready` out 1: controller idle and able to accept.
- `KCLK` in 1: raw PS/2 clock line, asynchronous.
- `KDAT` in 1: raw PS/2 data line, asynchronous.
- `kclk_oe` out 1: 1 drives KCLK low; 0 releases it (pulled up externally).
- `kdat_oe` out 1: 1 drives KDAT low; 0 releases it.
- `rx_enable` out 1: 1 permits the receiver to capture frames.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle pulse, transaction ended with a valid ACK.
- `err` out 1: one-cycle pulse, transaction ended by timeout or missing ACK.

## Operation
- KCLK and KDAT pass through 2-flop synchronizers. A falling edge is synchronized KCLK with previous = 1 and current = 0.
- **IDLE**
  - `cmd_ready` = 1, `rx_enable` = 1, both `oe` = 0.
  - On `cmd_valid` & `cmd_ready`: latch `cmd_data`, compute odd parity (parity bit = ~^data), go to INHIBIT.
- **INHIBIT**
  - `kclk_oe` = 1, `rx_enable` = 0.
  - Counts `INHIBIT_CYC` cycles, then sets `kdat_oe` = 1 (start bit) and goes to RTS.
- **RTS**
  - One cycle: `kclk_oe` = 0, `kdat_oe` stays 1.
  - Clears the timeout counter and the bit counter, then goes to SHIFT.
- **SHIFT**
  - On each falling edge, the bit counter n (0..9) advances and the next bit is presented.
  - n = 0..7: `kdat_oe` = ~data[n].
  - n = 8: `kdat_oe` = ~parity.
  - n = 9: `kdat_oe` = 0 (stop bit, line released).
  - After the 10th falling edge, go to ACK.
- **ACK**
  - On the next falling edge, sample synchronized KDAT.
  - KDAT = 0: go to WAIT_IDLE with the ACK flag set.
  - KDAT = 1: go to WAIT_IDLE with the error flag set.
- **WAIT_IDLE**
  - Wait until synchronized KCLK = 1 and KDAT = 1.
  - Then pulse `done` (ACK flag) or `err` (error flag) and go to IDLE.
- **Timeout**
  - The counter runs in SHIFT and ACK.
  - Reaching `TIMEOUT_CYC` forces `kdat_oe` = 0, `kclk_oe` = 0, an `err` pulse, and IDLE.
  - Timeout has priority over a same-cycle falling edge.
- `busy` = ~IDLE.
- `cmd_valid` while busy is ignored (not queued).

## Timing
- Reset values:
  - `kclk_oe` = 0, `kdat_oe` = 0, `cmd_ready` = 1, `rx_enable` = 1.
  - `busy` = 0, `done` = 0, `err` = 0, state = IDLE, synchronizers = 1.
- Reset mid-transaction releases both lines immediately (asynchronous) with no pulse.
- Outputs are registered:
  - `kclk_oe` rises in the cycle after acceptance.
  - It stays high exactly `INHIBIT_CYC` cycles.
  - `kdat_oe` rises in the last of those cycles, so KDAT is low at least 1 cycle before KCLK is released.
- Data bit updates land 3 clk cycles after the raw KCLK falling edge (2 synchronizer stages plus the edge register). The device samples on the rising edge, so the update occurs during the KCLK-low half.
- `rx_enable` drops in the cycle after acceptance and returns high in the cycle after `done`/`err`.
- `done` and `err` are mutually exclusive; each is exactly 1 cycle.
- A new command can be accepted in the cycle after `done`/`err`.

## Test plan
- `INHIBIT_CYC` = 20: accept 0xED → `kclk_oe` high for 20 cycles; KDAT driven low before KCLK release; `rx_enable` = 0 throughout.
- Device model clocks 11 edges at 10 kHz with ACK low → KDAT bits observed are 1,0,1,1,0,1,1,1 (0xED LSB first), then parity 1, then stop 1; `done` pulses once; `err` = 0.
- Send 0xF4 → bits 0,0,1,0,1,1,1,1, then parity 0; `done` pulses.
- Device holds KDAT high on the 11th edge → `err` pulses; `done` = 0; back in IDLE with `cmd_ready` = 1.
- `TIMEOUT_CYC` = 200 and the device stops clocking after 4 edges → `err` exactly 200 cycles after KCLK release; both `oe` = 0.
- Assert `reset` = 0 during SHIFT → both `oe` = 0 the same cycle; no pulse; after release, a 0xF4 transaction completes normally.
